// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch (IF) and load/store (LS).
// One access at a time: ISSUE (1 cycle) -> WAIT (RD_LAT cycles) -> RESP (1 cycle).
// LS has priority. A saturating starvation counter forces an IF win after
// MAX_STARVE consecutive losses while IF was requesting.
//
// Handshake: a requester raises *_req_i and holds it, with its address and data,
// until it sees *_gnt_o. *_gnt_o is a one-cycle pulse in the cycle the access is
// driven onto the RAM. *_rvalid_o is a one-cycle pulse exactly RD_LAT+1 cycles
// later, with *_rdata_o valid. For stores, ls_rdata_o is 0. Requester inputs are
// only looked at in the arbitration cycle (IDLE or RESP). A request withdrawn
// before its grant is simply forgotten.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i,
  output logic          busy_o,
  output logic [1:0]    dbg_state_o,
  output logic [3:0]    dbg_starve_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_t        r_state;
  logic [2:0]    r_wait_cnt;
  logic [3:0]    r_starve_cnt;
  logic          r_owner_ls;
  logic          r_owner_store;
  logic          r_if_gnt;
  logic          r_ls_gnt;
  logic          r_if_rvalid;
  logic          r_ls_rvalid;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_ls_rdata;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_data;

  logic          w_any_req;
  logic          w_if_forced;
  logic          w_ls_win;
  logic          w_if_win;
  logic          w_ls_store;
  logic [3:0]    w_starve_nxt;

  // Arbitration decision and next starvation count, used only in IDLE/RESP.
  always_comb begin
    w_any_req    = if_req_i | ls_req_i;
    w_if_forced  = if_req_i & (r_starve_cnt == STARVE_MAX);
    w_ls_win     = ls_req_i & ~w_if_forced;
    w_if_win     = if_req_i & ~w_ls_win;
    w_ls_store   = w_ls_win & ls_we_i;
    w_starve_nxt = 4'd0;
    if (if_req_i && !w_if_win) begin
      w_starve_nxt = (r_starve_cnt == STARVE_MAX) ? r_starve_cnt : r_starve_cnt + 4'd1;
    end
  end

  // Access sequencer: arbitration, RAM drive, latency count and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 3'd0;
      r_starve_cnt  <= 4'd0;
      r_owner_ls    <= 1'b0;
      r_owner_store <= 1'b0;
      r_if_gnt      <= 1'b0;
      r_ls_gnt      <= 1'b0;
      r_if_rvalid   <= 1'b0;
      r_ls_rvalid   <= 1'b0;
      r_if_rdata    <= '0;
      r_ls_rdata    <= '0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data    <= '0;
    end else begin
      // Pulses last one cycle unless re-asserted below.
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ram_we    <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          r_starve_cnt <= w_starve_nxt;
          if (w_any_req) begin
            r_state       <= S_ISSUE;
            r_owner_ls    <= w_ls_win;
            r_owner_store <= w_ls_store;
            r_if_gnt      <= w_if_win;
            r_ls_gnt      <= w_ls_win;
            r_ram_we      <= w_ls_store;
            r_ram_addr    <= w_ls_win ? ls_addr_i : if_addr_i;
            r_ram_data    <= w_ls_store ? ls_wdata_i : '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= 3'd0;
          r_ram_data <= '0;
        end
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= S_RESP;
            if (r_owner_ls) begin
              r_ls_rdata  <= r_owner_store ? '0 : ram_data_i;
              r_ls_rvalid <= 1'b1;
            end else begin
              r_if_rdata  <= ram_data_i;
              r_if_rvalid <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_gnt_o     = r_if_gnt;
  assign ls_gnt_o     = r_ls_gnt;
  assign if_rvalid_o  = r_if_rvalid;
  assign ls_rvalid_o  = r_ls_rvalid;
  assign if_rdata_o   = r_if_rdata;
  assign ls_rdata_o   = r_ls_rdata;
  assign ram_we_o     = r_ram_we;
  assign ram_addr_o   = r_ram_addr;
  assign ram_data_o   = r_ram_data;
  assign busy_o       = (r_state != S_IDLE);
  assign dbg_state_o  = r_state;
  assign dbg_starve_o = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3 share the requester inputs and reset; each has its own RAM model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;

  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_we, busy;
  logic [31:0] if_rdata, ls_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve;

  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, ram_we3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
  logic [1:0]  dbg_state3;
  logic [3:0]  dbg_starve3;

  logic        poke_en1, poke_en3;
  logic [7:0]  poke_addr;
  logic [31:0] poke_data;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  int checks = 0;
  int errors = 0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
    .ram_data_i(ram_rdata), .busy_o(busy),
    .dbg_state_o(dbg_state), .dbg_starve_o(dbg_starve)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_STARVE(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt3),
    .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt3), .ls_rvalid_o(ls_rvalid3), .ls_rdata_o(ls_rdata3),
    .ram_we_o(ram_we3), .ram_addr_o(ram_addr3), .ram_data_o(ram_wdata3),
    .ram_data_i(ram_rdata3), .busy_o(busy3),
    .dbg_state_o(dbg_state3), .dbg_starve_o(dbg_starve3)
  );

  // RAM models: one-cycle registered read, write on edge when we is high.
  always @(posedge clk) begin
    if (poke_en1) mem1[poke_addr] <= poke_data;
    else if (ram_we) mem1[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem1[ram_addr[7:0]];
  end

  always @(posedge clk) begin
    if (poke_en3) mem3[poke_addr] <= poke_data;
    else if (ram_we3) mem3[ram_addr3[7:0]] <= ram_wdata3;
    ram_rdata3 <= mem3[ram_addr3[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic sel3, input logic [7:0] a, input logic [31:0] d);
    poke_en1  = ~sel3;
    poke_en3  = sel3;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en1 = 1'b0;
    poke_en3 = 1'b0;
  endtask

  initial begin : stim
    logic [5:0]  exp_seq;
    logic [31:0] got;
    int          n;
    int          last;
    int          overlap;
    int          rv_cnt;

    reset = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    poke_en1 = 1'b0; poke_en3 = 1'b0; poke_addr = '0; poke_data = '0;

    // Preload RAM while reset is held.
    poke(1'b0, 8'h10, 32'hDEADBEEF);
    poke(1'b0, 8'h40, 32'h00000777);
    poke(1'b1, 8'h30, 32'hAAAA0001);

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
    chk("rst_starve", {28'd0, dbg_starve}, 32'd0);
    reset = 1'b1;
    tick();

    // Single IF fetch
    if_addr = 32'h10; if_req = 1'b1;
    tick();
    chk("if_gnt_c1", {31'd0, if_gnt}, 32'd1);
    chk("if_ls_gnt_c1", {31'd0, ls_gnt}, 32'd0);
    chk("if_addr_c1", ram_addr, 32'h10);
    chk("if_we_c1", {31'd0, ram_we}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("if_gnt_c2", {31'd0, if_gnt}, 32'd0);
    chk("if_rvalid_c2", {31'd0, if_rvalid}, 32'd0);
    tick();
    chk("if_rvalid_c3", {31'd0, if_rvalid}, 32'd1);
    chk("if_rdata_c3", if_rdata, 32'hDEADBEEF);
    tick();
    chk("if_rvalid_c4", {31'd0, if_rvalid}, 32'd0);
    chk("if_idle_c4", {31'd0, busy}, 32'd0);
    chk("if_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Store then load back
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h1234;
    tick();
    chk("st_gnt_c1", {31'd0, ls_gnt}, 32'd1);
    chk("st_we_c1", {31'd0, ram_we}, 32'd1);
    chk("st_addr_c1", ram_addr, 32'h20);
    chk("st_data_c1", ram_wdata, 32'h1234);
    ls_req = 1'b0;
    tick();
    chk("st_we_c2", {31'd0, ram_we}, 32'd0);
    chk("st_addr_c2", ram_addr, 32'h20);
    tick();
    chk("st_rvalid_c3", {31'd0, ls_rvalid}, 32'd1);
    chk("st_rdata_c3", ls_rdata, 32'd0);
    tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    tick();
    chk("ld_gnt_c1", {31'd0, ls_gnt}, 32'd1);
    chk("ld_we_c1", {31'd0, ram_we}, 32'd0);
    ls_req = 1'b0;
    tick();
    tick();
    chk("ld_rvalid_c3", {31'd0, ls_rvalid}, 32'd1);
    chk("ld_rdata_c3", ls_rdata, 32'h1234);
    chk("ld_if_rdata_hold", if_rdata, 32'hDEADBEEF);
    tick();

    // Contention: grant order, period, starvation counter
    exp_seq = 6'b010000;
    if_addr = 32'h10; ls_addr = 32'h20; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    n = 0; last = 0; overlap = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      tick();
      if ((if_gnt && if_rvalid) || (ls_gnt && ls_rvalid)) overlap++;
      if (if_gnt || ls_gnt) begin
        got = {31'd0, if_gnt};
        chk($sformatf("grant_%0d_is_if", n), got, {31'd0, exp_seq[n]});
        if (n > 0) chk($sformatf("period_%0d", n), cyc - last, 32'd3);
        if (n == 3) chk("starve_sat", {28'd0, dbg_starve}, 32'd4);
        if (if_gnt) chk("starve_clr", {28'd0, dbg_starve}, 32'd0);
        last = cyc;
        n++;
      end
    end
    chk("grant_count", n, 32'd6);
    chk("gnt_rvalid_overlap", overlap, 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    for (int cyc = 0; cyc < 10 && busy; cyc++) tick();
    chk("contention_idle", {31'd0, busy}, 32'd0);

    // Reset during ISSUE of a store: write enable must drop at once
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h5555;
    tick();
    chk("abort_we_before", {31'd0, ram_we}, 32'd1);
    ls_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_we_async", {31'd0, ram_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rv_cnt += int'(ls_rvalid) + int'(if_rvalid);
    end
    chk("abort_no_rvalid", rv_cnt, 32'd0);

    // Reset during WAIT of a load
    ls_we = 1'b0; ls_addr = 32'h40; ls_req = 1'b1;
    tick();
    ls_req = 1'b0;
    tick();
    chk("rw_in_wait", {30'd0, dbg_state}, 32'd2);
    reset = 1'b0;
    #1;
    chk("rw_outputs_zero", {ram_addr[29:0], busy, ls_gnt}, 32'd0);
    chk("rw_rvalid_zero", {31'd0, ls_rvalid}, 32'd0);
    tick();
    reset = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rv_cnt += int'(ls_rvalid) + int'(if_rvalid);
    end
    chk("rw_no_rvalid", rv_cnt, 32'd0);

    // Next request completes; aborted store left RAM untouched
    ls_req = 1'b1;
    tick();
    chk("post_gnt", {31'd0, ls_gnt}, 32'd1);
    ls_req = 1'b0;
    tick();
    tick();
    chk("post_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("post_rdata", ls_rdata, 32'h00000777);

    // RD_LAT=3 instance: clean start
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    if_addr = 32'h30; if_req = 1'b1;
    tick();
    chk("l3_gnt_c1", {31'd0, if_gnt3}, 32'd1);
    if_req = 1'b0;
    tick();
    // Change the word in cycle 2 so only a capture in the 3rd WAIT cycle sees it.
    poke_en3 = 1'b1; poke_addr = 8'h30; poke_data = 32'hBBBB0002;
    tick();
    poke_en3 = 1'b0;
    chk("l3_rvalid_c3", {31'd0, if_rvalid3}, 32'd0);
    tick();
    chk("l3_rvalid_c4", {31'd0, if_rvalid3}, 32'd0);
    tick();
    chk("l3_rvalid_c5", {31'd0, if_rvalid3}, 32'd1);
    chk("l3_rdata_c5", if_rdata3, 32'hBBBB0002);
    tick();
    chk("l3_rvalid_c6", {31'd0, if_rvalid3}, 32'd0);
    chk("l3_idle", {31'd0, busy3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
